capture_ctrl: RTL and testbench



---
 rtl/capture_ctrl.sv | 165 ++++++++++++++++
 tb/tb_capture_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : capture_ctrl
// Description : Acquisition controller downstream of the trigger stage.
//               Streams ADC samples into a circular buffer, freezes a
//               window of PRE pre-trigger plus DEPTH-PRE post-trigger
//               samples around the capture event, and exposes a
//               trigger-aligned registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ctrl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic                     trig,
    input  logic                     force_trig,
    input  logic                     arm,
    input  logic        [ADDR_W-1:0] pretrig_len,
    input  logic        [ADDR_W-1:0] rd_idx,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     armed,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH = 1 << ADDR_W;
    // Window length needs one extra bit: with pre = 0 the post count is DEPTH.
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRE_FILL = 3'd1,
        S_ARMED    = 3'd2,
        S_POST     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic        [ADDR_W-1:0]  r_wptr;
    logic        [ADDR_W:0]    r_cnt;
    logic        [ADDR_W:0]    w_next_cnt;
    logic        [ADDR_W-1:0]  r_pre;
    logic        [ADDR_W-1:0]  w_next_pre;
    logic        [ADDR_W-1:0]  r_start;
    logic        [ADDR_W-1:0]  w_next_start;
    logic                      r_trig_d;
    logic                      w_wr;
    logic                      w_event;
    logic        [ADDR_W:0]    w_cnt_inc;
    logic        [ADDR_W:0]    w_post_len;
    logic        [ADDR_W-1:0]  w_rd_addr;
    logic signed [DATA_W-1:0]  r_mem [DEPTH];

    // Capture event: rising trigger edge or forced trigger, qualified by en.
    assign w_event    = en & ((trig & ~r_trig_d) | force_trig);
    assign w_cnt_inc  = r_cnt + c_one;
    assign w_post_len = c_depth - {1'b0, r_pre};
    // Read index is relative to the oldest sample; address wraps mod DEPTH.
    assign w_rd_addr  = r_start + rd_idx;

    // Next-state, counter and write-enable decode; arm overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_pre   = r_pre;
        w_next_start = r_start;
        w_wr         = 1'b0;
        if (arm) begin
            // Restart: a coincident event and the current sample are dropped.
            w_next_pre   = pretrig_len;
            w_next_cnt   = '0;
            w_next_state = (pretrig_len == '0) ? S_ARMED : S_PRE_FILL;
        end else begin
            case (r_state)
                S_PRE_FILL: begin
                    // Events are ignored until the pre-trigger history is full.
                    if (en) begin
                        w_wr       = 1'b1;
                        w_next_cnt = w_cnt_inc;
                        if (w_cnt_inc == {1'b0, r_pre}) begin
                            w_next_state = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (en) begin
                        w_wr = 1'b1;
                        if (w_event) begin
                            // Trigger sample lands at the current wptr.
                            w_next_start = r_wptr - r_pre;
                            w_next_cnt   = c_one;
                            w_next_state = (w_post_len == c_one) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (en) begin
                        w_wr       = 1'b1;
                        w_next_cnt = w_cnt_inc;
                        if (w_cnt_inc == w_post_len) begin
                            w_next_state = S_DONE;
                        end
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    // State, pointers, edge-detect history and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wptr   <= '0;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_start  <= '0;
            r_trig_d <= 1'b0;
            armed    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_pre   <= w_next_pre;
            r_start <= w_next_start;
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (en) begin
                r_trig_d <= trig;
            end
            armed <= (w_next_state == S_ARMED);
            busy  <= (w_next_state == S_PRE_FILL) || (w_next_state == S_ARMED) ||
                     (w_next_state == S_POST);
            done  <= (w_next_state == S_DONE);
        end
    end

    // Sample buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= sample;
        end
    end

    // Trigger-aligned read port, one cycle latency, independent of writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_mem[w_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_ctrl
// Description : Directed self-checking bench for capture_ctrl (DEPTH = 16).
//               Ramp samples make every buffer word equal to its stream
//               index, so expected window contents follow from the trigger
//               index and the pre-trigger length alone.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_ctrl;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic signed [DATA_W-1:0] sample;
    logic                     trig;
    logic                     force_trig;
    logic                     arm;
    logic        [ADDR_W-1:0] pretrig_len;
    logic        [ADDR_W-1:0] rd_idx;
    logic signed [DATA_W-1:0] rd_data;
    logic                     armed;
    logic                     busy;
    logic                     done;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sample      (sample),
        .trig        (trig),
        .force_trig  (force_trig),
        .arm         (arm),
        .pretrig_len (pretrig_len),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .armed       (armed),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input logic t, input logic ft, input logic e);
        sample     = DATA_W'(v);
        trig       = t;
        force_trig = ft;
        en         = e;
        tick();
        en         = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic do_arm(input int p);
        pretrig_len = ADDR_W'(p);
        arm         = 1'b1;
        en          = 1'b0;
        force_trig  = 1'b0;
        tick();
        arm         = 1'b0;
    endtask

    // Window word i must be stream sample (first + i).
    task automatic read_window(input string tag, input int first);
        logic [DATA_W-1:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = ADDR_W'(i);
            exp_q.push_back(DATA_W'(first + i));
            tick();
            e = exp_q.pop_front();
            chk(tag, 32'(unsigned'(rd_data)), 32'(e));
        end
    endtask

    task automatic chk_status(input string tag, input logic a, input logic b, input logic d);
        chk({tag, "_armed"}, 32'(armed), 32'(a));
        chk({tag, "_busy"},  32'(busy),  32'(b));
        chk({tag, "_done"},  32'(done),  32'(d));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sample = '0; trig = 1'b0; force_trig = 1'b0;
        arm = 1'b0; pretrig_len = '0; rd_idx = '0;
        tick(); tick();
        chk_status("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_rd_data", 32'(unsigned'(rd_data)), 32'd0);
        rst = 1'b0;
        tick();

        // Basic window: pre=4, trigger edge on sample 20.
        do_arm(4);
        chk_status("basic_prefill", 1'b0, 1'b1, 1'b0);
        for (int v = 0; v < 3; v++) feed(v, 1'b0, 1'b0, 1'b1);
        chk("basic_not_yet_armed", 32'(armed), 32'd0);
        feed(3, 1'b0, 1'b0, 1'b1);
        chk("basic_armed_after_4", 32'(armed), 32'd1);
        for (int v = 4; v < 20; v++) feed(v, 1'b0, 1'b0, 1'b1);
        feed(20, 1'b1, 1'b0, 1'b1);
        chk_status("basic_post", 1'b0, 1'b1, 1'b0);
        for (int v = 21; v < 31; v++) feed(v, 1'b1, 1'b0, 1'b1);
        chk("basic_done_early", 32'(done), 32'd0);
        feed(31, 1'b1, 1'b0, 1'b1);
        chk_status("basic_done", 1'b0, 1'b0, 1'b1);
        read_window("basic_rd", 16);

        // pre=0: straight to ARMED, trigger on sample 7.
        do_arm(0);
        chk_status("pre0_armed", 1'b1, 1'b1, 1'b0);
        for (int v = 0; v < 7; v++) feed(v, 1'b0, 1'b0, 1'b1);
        feed(7, 1'b1, 1'b0, 1'b1);
        for (int v = 8; v < 22; v++) feed(v, 1'b1, 1'b0, 1'b1);
        chk("pre0_done_early", 32'(done), 32'd0);
        feed(22, 1'b0, 1'b0, 1'b1);
        chk("pre0_done", 32'(done), 32'd1);
        read_window("pre0_rd", 7);

        // Trig high through PRE_FILL: no edge in ARMED; force_trig on sample 9.
        do_arm(2);
        for (int v = 0; v < 9; v++) feed(v, 1'b1, 1'b0, 1'b1);
        chk_status("level_no_capture", 1'b1, 1'b1, 1'b0);
        feed(9, 1'b1, 1'b1, 1'b1);
        chk("force_post", 32'(armed), 32'd0);
        for (int v = 10; v < 23; v++) feed(v, 1'b1, 1'b0, 1'b1);
        chk("force_done", 32'(done), 32'd1);
        read_window("force_rd", 7);

        // Wrap-around: several laps, pre=6, trigger on 40.
        do_arm(6);
        for (int v = 0; v < 40; v++) feed(v, 1'b0, 1'b0, 1'b1);
        feed(40, 1'b1, 1'b0, 1'b1);
        for (int v = 41; v < 49; v++) feed(v, 1'b0, 1'b0, 1'b1);
        chk("wrap_done_early", 32'(done), 32'd0);
        feed(49, 1'b0, 1'b0, 1'b1);
        chk("wrap_done", 32'(done), 32'd1);
        read_window("wrap_rd", 34);

        // en toggling: pulses on en=0 cycles ignored; only en cycles written.
        do_arm(4);
        for (int v = 0; v < 6; v++) feed(v, 1'b0, 1'b0, 1'b1);
        feed(999, 1'b1, 1'b1, 1'b0);
        chk("en0_trig_ignored", 32'(armed), 32'd1);
        for (int v = 6; v < 10; v++) feed(v, 1'b0, 1'b0, 1'b1);
        feed(10, 1'b1, 1'b0, 1'b1);
        for (int v = 11; v < 22; v++) begin
            feed(1000 + v, ~trig, 1'b0, 1'b0);
            feed(v, 1'b0, 1'b0, 1'b1);
            if (v == 20) chk("entog_done_early", 32'(done), 32'd0);
        end
        chk("entog_done", 32'(done), 32'd1);
        read_window("entog_rd", 6);

        // Re-arm during POST restarts from PRE_FILL.
        do_arm(3);
        for (int v = 0; v < 6; v++) feed(v, 1'b0, 1'b0, 1'b1);
        feed(6, 1'b1, 1'b0, 1'b1);
        feed(7, 1'b1, 1'b0, 1'b1);
        chk("rearm_in_post", 32'(armed), 32'd0);
        do_arm(5);
        chk_status("rearm_prefill", 1'b0, 1'b1, 1'b0);
        for (int v = 100; v < 104; v++) feed(v, 1'b0, 1'b0, 1'b1);
        chk("rearm_not_armed", 32'(armed), 32'd0);
        feed(104, 1'b0, 1'b0, 1'b1);
        chk("rearm_armed", 32'(armed), 32'd1);

        // Asynchronous reset in ARMED, checked before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_status("async_rst", 1'b0, 1'b0, 1'b0);
        chk("async_rst_rd_data", 32'(unsigned'(rd_data)), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_status("rst_idle", 1'b0, 1'b0, 1'b0);

        // pre = DEPTH-1: trigger sample completes the window directly.
        do_arm(15);
        for (int v = 0; v < 15; v++) feed(v, 1'b0, 1'b0, 1'b1);
        chk("pre15_armed", 32'(armed), 32'd1);
        feed(15, 1'b1, 1'b0, 1'b1);
        chk_status("pre15_done", 1'b0, 1'b0, 1'b1);
        read_window("pre15_rd", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
